traffic_light_monitor: RTL and testbench

Passive checker and lamp driver on the receiving end of the two-direction light-code bus driven by the intersection controller. It samples the 2-bit light codes for directions A and B and decodes them to one-hot lamp drives. It checks every transition against the green→yellow→red→green sequence, mutual exclusion, and dwell limits. Violations raise sticky error flags, and completed A-direction cycles are counted for the status register block.

---
 rtl/traffic_light_monitor.sv | 133 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the two-direction light-code bus: decodes one-hot lamp
// drives and raises sticky sequence, conflict, illegal-code and dwell errors.
module traffic_light_monitor #(
  parameter int unsigned MIN_GREEN  = 1,
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned MAX_YELLOW = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  L_A,
  input  logic [1:0]  L_B,
  input  logic        clr_err,
  output logic [2:0]  lamp_a,
  output logic [2:0]  lamp_b,
  output logic        err_conflict,
  output logic        err_seq,
  output logic        err_code,
  output logic        err_dwell,
  output logic        error,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ILLEGAL = 2'b10,
    RED     = 2'b11
  } light_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             seq;
    logic             dwell;
  } chk_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_Y   = CNT_W'(MAX_YELLOW);

  light_t           a_q, b_q, a_p, b_p;
  logic             samp_vld, prev_vld;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  chk_t chk_a, chk_b;
  logic conf_nxt, seq_nxt, code_nxt, dwell_nxt, cyc_hit;

  function automatic logic [2:0] decode(light_t c);
    logic [2:0] l;
    case (c)
      GREEN:   l = 3'b001;
      YELLOW:  l = 3'b010;
      default: l = 3'b100;
    endcase
    return l;
  endfunction

  function automatic logic is_lit(light_t c);
    return (c == GREEN) || (c == YELLOW);
  endfunction

  // cnt holds how many samples the code in x_p has been stable, so a
  // departure is judged against the dwell of the code being left.
  function automatic chk_t check(light_t q, light_t p, logic [CNT_W-1:0] cnt,
                                 logic vld);
    chk_t r;
    logic change, load, legal;
    change = vld && (q != p);
    load   = !vld || (q != p);
    legal  = (p == GREEN  && q == YELLOW) ||
             (p == YELLOW && q == RED)    ||
             (p == RED    && q == GREEN);
    r.cnt   = load ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : cnt + CNT_ONE);
    r.seq   = change && (q != ILLEGAL) && (p != ILLEGAL) && !legal;
    // Yellow overstay fires only on the step into MAX_Y; a saturated counter
    // never steps again, so it cannot retrigger.
    r.dwell = (change && p == GREEN  && cnt < MIN_G) ||
              (change && p == YELLOW && cnt < MIN_Y) ||
              (q == YELLOW && r.cnt == MAX_Y && (load || cnt != CNT_MAX));
    return r;
  endfunction

  always_comb begin
    chk_a     = check(a_q, a_p, cnt_a, prev_vld);
    chk_b     = check(b_q, b_p, cnt_b, prev_vld);
    conf_nxt  = (err_conflict & ~clr_err) | (is_lit(a_q) & is_lit(b_q));
    seq_nxt   = (err_seq      & ~clr_err) | chk_a.seq | chk_b.seq;
    code_nxt  = (err_code     & ~clr_err) | (a_q == ILLEGAL) | (b_q == ILLEGAL);
    dwell_nxt = (err_dwell    & ~clr_err) | chk_a.dwell | chk_b.dwell;
    cyc_hit   = prev_vld && (a_p == RED) && (a_q == GREEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q          <= RED;
      b_q          <= RED;
      a_p          <= RED;
      b_p          <= RED;
      samp_vld     <= 1'b0;
      prev_vld     <= 1'b0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      lamp_a       <= 3'b100;
      lamp_b       <= 3'b100;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_code     <= 1'b0;
      err_dwell    <= 1'b0;
      error        <= 1'b0;
      cycle_count  <= '0;
    end else begin
      a_q          <= light_t'(L_A);
      b_q          <= light_t'(L_B);
      a_p          <= a_q;
      b_p          <= b_q;
      samp_vld     <= 1'b1;
      prev_vld     <= samp_vld;
      cnt_a        <= chk_a.cnt;
      cnt_b        <= chk_b.cnt;
      lamp_a       <= decode(a_q);
      lamp_b       <= decode(b_q);
      err_conflict <= conf_nxt;
      err_seq      <= seq_nxt;
      err_code     <= code_nxt;
      err_dwell    <= dwell_nxt;
      error        <= conf_nxt | seq_nxt | code_nxt | dwell_nxt;
      if (cyc_hit) cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: vector table plus hand-written
// multi-cycle sequences (dwell limits, mid-operation reset).
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  L_A = 2'b11, L_B = 2'b11;
  logic        clr_err = 1'b0;
  logic [2:0]  lamp_a, lamp_b;
  logic        err_conflict, err_seq, err_code, err_dwell, error;
  logic [15:0] cycle_count;

  logic [1:0]  g_la = 2'b11, g_lb = 2'b11;
  logic        g_clr = 1'b0;
  logic [2:0]  g_lamp_a, g_lamp_b;
  logic        g_conflict, g_seq, g_code, g_dwell, g_error;
  logic [15:0] g_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_GREEN(1), .MIN_YELLOW(1), .MAX_YELLOW(8), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .L_A(L_A), .L_B(L_B), .clr_err(clr_err),
    .lamp_a(lamp_a), .lamp_b(lamp_b), .err_conflict(err_conflict),
    .err_seq(err_seq), .err_code(err_code), .err_dwell(err_dwell),
    .error(error), .cycle_count(cycle_count)
  );

  traffic_light_monitor #(
    .MIN_GREEN(3)
  ) dut_g (
    .clk(clk), .reset_n(reset_n), .L_A(g_la), .L_B(g_lb), .clr_err(g_clr),
    .lamp_a(g_lamp_a), .lamp_b(g_lamp_b), .err_conflict(g_conflict),
    .err_seq(g_seq), .err_code(g_code), .err_dwell(g_dwell),
    .error(g_error), .cycle_count(g_count)
  );

  typedef struct {
    logic [1:0]  la;
    logic [1:0]  lb;
    logic        clr;
    logic [2:0]  ela;
    logic [2:0]  elb;
    logic [4:0]  efl;   // {conflict, seq, code, dwell, error}
    logic [15:0] ecnt;
  } vec_t;

  vec_t       tbl [16];
  logic [1:0] pat_a [8];
  logic [1:0] pat_b [8];
  logic [1:0] sh_a [4];
  logic [1:0] sh_b [4];

  function automatic logic [2:0] lamp_of(logic [1:0] c);
    case (c)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [4:0] flags_now();
    return {err_conflict, err_seq, err_code, err_dwell, error};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] la, input logic [1:0] lb,
                      input logic clr);
    L_A = la;
    L_B = lb;
    clr_err = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] prev_a, prev_b;

    pat_a = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    pat_b = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
    sh_a  = '{2'b00, 2'b01, 2'b11, 2'b11};
    sh_b  = '{2'b11, 2'b11, 2'b00, 2'b01};

    tbl[0]  = '{2'b00, 2'b11, 1'b0, 3'b100, 3'b100, 5'b00000, 16'd0};
    tbl[1]  = '{2'b00, 2'b11, 1'b0, 3'b001, 3'b100, 5'b00000, 16'd0};
    tbl[2]  = '{2'b11, 2'b11, 1'b0, 3'b001, 3'b100, 5'b00000, 16'd0};
    tbl[3]  = '{2'b11, 2'b11, 1'b0, 3'b100, 3'b100, 5'b01001, 16'd0};
    tbl[4]  = '{2'b11, 2'b11, 1'b1, 3'b100, 3'b100, 5'b00000, 16'd0};
    tbl[5]  = '{2'b11, 2'b11, 1'b0, 3'b100, 3'b100, 5'b00000, 16'd0};
    tbl[6]  = '{2'b00, 2'b11, 1'b0, 3'b100, 3'b100, 5'b00000, 16'd0};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 3'b001, 3'b100, 5'b00000, 16'd1};
    tbl[8]  = '{2'b00, 2'b11, 1'b0, 3'b001, 3'b001, 5'b10001, 16'd1};
    tbl[9]  = '{2'b00, 2'b11, 1'b0, 3'b001, 3'b100, 5'b11001, 16'd1};
    tbl[10] = '{2'b00, 2'b11, 1'b1, 3'b001, 3'b100, 5'b00000, 16'd1};
    tbl[11] = '{2'b00, 2'b10, 1'b0, 3'b001, 3'b100, 5'b00000, 16'd1};
    tbl[12] = '{2'b00, 2'b11, 1'b0, 3'b001, 3'b100, 5'b00101, 16'd1};
    tbl[13] = '{2'b00, 2'b11, 1'b0, 3'b001, 3'b100, 5'b00101, 16'd1};
    tbl[14] = '{2'b00, 2'b11, 1'b1, 3'b001, 3'b100, 5'b00000, 16'd1};
    tbl[15] = '{2'b00, 2'b11, 1'b0, 3'b001, 3'b100, 5'b00000, 16'd1};

    // Reset state
    do_reset();
    check("reset lamp_a", lamp_a, 3'b100);
    check("reset lamp_b", lamp_b, 3'b100);
    check("reset flags", flags_now(), 5'b00000);
    check("reset cycle_count", cycle_count, 16'd0);

    // Legal sequence, four full cycles; lamps lag inputs by two edges
    prev_a = 2'b11;
    prev_b = 2'b11;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 8; s++) begin
        step(pat_a[s], pat_b[s], 1'b0);
        check($sformatf("legal r%0d s%0d lamp_a", r, s), lamp_a, lamp_of(prev_a));
        check($sformatf("legal r%0d s%0d lamp_b", r, s), lamp_b, lamp_of(prev_b));
        check($sformatf("legal r%0d s%0d flags", r, s), flags_now(), 5'b00000);
        prev_a = pat_a[s];
        prev_b = pat_b[s];
      end
      check($sformatf("legal r%0d cycle_count", r), cycle_count, r);
    end

    // Vector table: bad sequence, clear, conflict, illegal code
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].la, tbl[i].lb, tbl[i].clr);
      check($sformatf("tbl%0d lamp_a", i), lamp_a, tbl[i].ela);
      check($sformatf("tbl%0d lamp_b", i), lamp_b, tbl[i].elb);
      check($sformatf("tbl%0d flags", i), flags_now(), tbl[i].efl);
      check($sformatf("tbl%0d cycle_count", i), cycle_count, tbl[i].ecnt);
    end

    // Yellow overstay: flag appears one edge after the 8th yellow sample
    do_reset();
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step(2'b01, 2'b11, 1'b0);
      if (i >= 7) check($sformatf("yellow hold %0d err_dwell", i), err_dwell, (i == 9));
    end
    check("yellow overstay error", error, 1'b1);
    check("yellow overstay err_seq", err_seq, 1'b0);
    step(2'b01, 2'b11, 1'b1);
    check("yellow clr err_dwell", err_dwell, 1'b0);
    repeat (260) step(2'b01, 2'b11, 1'b0);
    check("yellow saturate no retrigger", err_dwell, 1'b0);
    check("yellow saturate error", error, 1'b0);

    // MIN_GREEN=3 instance: two green samples is short, three is enough
    step(2'b11, 2'b11, 1'b0);
    do_reset();
    g_la = 2'b00; step(2'b11, 2'b11, 1'b0);
    g_la = 2'b00; step(2'b11, 2'b11, 1'b0);
    g_la = 2'b01; step(2'b11, 2'b11, 1'b0);
    check("short green before leave", g_dwell, 1'b0);
    g_la = 2'b01; step(2'b11, 2'b11, 1'b0);
    check("short green err_dwell", g_dwell, 1'b1);
    check("short green err_seq", g_seq, 1'b0);
    do_reset();
    g_la = 2'b00; step(2'b11, 2'b11, 1'b0);
    g_la = 2'b00; step(2'b11, 2'b11, 1'b0);
    g_la = 2'b00; step(2'b11, 2'b11, 1'b0);
    g_la = 2'b01; step(2'b11, 2'b11, 1'b0);
    g_la = 2'b01; step(2'b11, 2'b11, 1'b0);
    check("full green err_dwell", g_dwell, 1'b0);
    g_la = 2'b11;

    // Mid-operation reset with cycle_count=5 and err_seq=1
    do_reset();
    for (int r = 0; r < 6; r++)
      for (int s = 0; s < 4; s++)
        step(sh_a[s], sh_b[s], 1'b0);
    step(2'b01, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    step(2'b01, 2'b11, 1'b0);
    check("pre-reset cycle_count", cycle_count, 16'd5);
    check("pre-reset err_seq", err_seq, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset lamp_a", lamp_a, 3'b100);
    check("async reset lamp_b", lamp_b, 3'b100);
    check("async reset flags", flags_now(), 5'b00000);
    check("async reset cycle_count", cycle_count, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    check("post-reset lamp_a", lamp_a, 3'b001);
    check("post-reset err_seq", err_seq, 1'b0);
    check("post-reset cycle_count", cycle_count, 16'd0);
    step(2'b00, 2'b11, 1'b0);
    check("post-reset flags", flags_now(), 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
